// File: rtl/result_arbiter_pkg.sv
// Shared constants and helpers for the result-FIFO write-port arbiter.
package result_arbiter_pkg;

  // Requester slots on the shared result port
  localparam int REQ_DDS      = 0;
  localparam int REQ_SPI      = 1;
  localparam int REQ_LOOPBACK = 2;

  localparam int N_REQ_DEF        = 3;
  localparam int RESULT_WIDTH_DEF = 32;
  localparam int QUEUE_DEPTH_DEF  = 4;

  // Index width that stays legal (>=1) for a single-entry range
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_arbiter_if.sv
// Bus bundle between requesters / result FIFO and the arbiter.
// RESULT_ARBITER_DBG_EN adds the debug counter outputs.
interface result_arbiter_if #(
  parameter int N_REQ        = 3,
  parameter int RESULT_WIDTH = 32
);
  logic                          flush;
  logic [N_REQ-1:0]              req_wr_en;
  logic [N_REQ*RESULT_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [RESULT_WIDTH-1:0]       result_data;
  logic                          result_wr_en;
  logic [N_REQ-1:0]              pending;
  logic                          idle;
  logic                          overflow;
  logic [N_REQ-1:0]              overflow_src;
  logic                          clear_overflow;
`ifdef RESULT_ARBITER_DBG_EN
  logic [N_REQ*32-1:0]           dbg_grant_count;
  logic [31:0]                   dbg_drop_count;
`endif

  // Arbiter side
  modport slave (
`ifdef RESULT_ARBITER_DBG_EN
    output dbg_grant_count, dbg_drop_count,
`endif
    input  flush, req_wr_en, req_data, fifo_full, clear_overflow,
    output result_data, result_wr_en, pending, idle, overflow, overflow_src
  );

  // Requester / FIFO side
  modport master (
`ifdef RESULT_ARBITER_DBG_EN
    input  dbg_grant_count, dbg_drop_count,
`endif
    output flush, req_wr_en, req_data, fifo_full, clear_overflow,
    input  result_data, result_wr_en, pending, idle, overflow, overflow_src
  );
endinterface

// File: rtl/result_arb_queue.sv
// Small per-requester synchronous FIFO; head is readable combinationally.
// The caller must not push when full unless it pops in the same cycle,
// and must not pop when empty.
module result_arb_queue
  import result_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = idx_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;

  // Extra pointer bit separates full from empty
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer update; flush discards all stored words
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; the head is read before this edge, so push+pop on full is safe
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/result_arbiter.sv
// Round-robin arbiter sharing the result-FIFO write port between requesters.
// Each requester has a private queue; drops set sticky overflow flags.
// Define RESULT_ARBITER_DBG_EN for per-requester grant and total drop counters.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int QUEUE_DEPTH  = QUEUE_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  result_arbiter_if.slave   bus
);
  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]                   full, empty, pop, push, drop;
  logic [N_REQ-1:0][RESULT_WIDTH-1:0] head;
  logic [IW-1:0]                      last_grant_q, last_grant_d, gnt_idx;
  logic [N_REQ-1:0]                   ovf_src_q, ovf_src_d;
  logic                               wr_en;
  int                                 cand;

  for (genvar i = 0; i < N_REQ; i++) begin : g_q
    // Push accepted if there is room, or room is made by this cycle's pop
    assign pop[i]  = wr_en & (gnt_idx == IW'(i));
    assign push[i] = bus.req_wr_en[i] & (~full[i] | pop[i]);
    assign drop[i] = bus.req_wr_en[i] & full[i] & ~pop[i];

    result_arb_queue #(.WIDTH(RESULT_WIDTH), .DEPTH(QUEUE_DEPTH)) u_q (
      .clock   (clock),
      .resetn  (resetn),
      .flush_i (bus.flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (bus.req_data[i*RESULT_WIDTH +: RESULT_WIDTH]),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Round-robin pick: scan from farthest to nearest so the nearest
  // non-empty queue after last_grant is the final assignment
  always_comb begin
    gnt_idx = '0;
    cand    = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(last_grant_q) + off) % N_REQ;
      if (!empty[IW'(cand)]) gnt_idx = IW'(cand);
    end
  end

  // fifo_full gates the strobe combinationally; the FIFO registers it
  assign wr_en            = ~(&empty) & ~bus.fifo_full;
  assign bus.result_wr_en = wr_en;
  assign bus.result_data  = wr_en ? head[gnt_idx] : '0;
  assign bus.pending      = ~empty;
  assign bus.idle         = &empty;
  assign bus.overflow     = |ovf_src_q;
  assign bus.overflow_src = ovf_src_q;

  // Next-state: a drop beats a coincident clear
  always_comb begin
    last_grant_d = last_grant_q;
    ovf_src_d    = ovf_src_q;
    if (bus.flush) begin
      last_grant_d = IW'(N_REQ - 1);
      ovf_src_d    = '0;
    end else begin
      if (wr_en) last_grant_d = gnt_idx;
      ovf_src_d = (bus.clear_overflow ? '0 : ovf_src_q) | drop;
    end
  end

  // Grant pointer and sticky flags; last_grant starts at N_REQ-1 so 0 wins first
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= IW'(N_REQ - 1);
      ovf_src_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ovf_src_q    <= ovf_src_d;
    end
  end

`ifdef RESULT_ARBITER_DBG_EN
  logic [N_REQ-1:0][31:0] gcnt_q;
  logic [31:0]            dcnt_q, ndrop;

  // Number of words dropped this cycle
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N_REQ; i++) ndrop = ndrop + {31'b0, drop[i]};
  end

  // Free-running wrap-around counters, untouched by clear_overflow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gcnt_q <= '0;
      dcnt_q <= '0;
    end else if (bus.flush) begin
      gcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (pop[i]) gcnt_q[i] <= gcnt_q[i] + 32'd1;
      dcnt_q <= dcnt_q + ndrop;
    end
  end

  assign bus.dbg_grant_count = gcnt_q;
  assign bus.dbg_drop_count  = dcnt_q;
`endif
endmodule

// File: tb/tb_result_arbiter.sv
// Scoreboard bench for result_arbiter: a queue-based reference model predicts
// each cycle's write and status; a negedge monitor compares against the DUT.
module tb_result_arbiter;
  import result_arbiter_pkg::*;

  localparam int N = 3;
  localparam int W = 32;
  localparam int D = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  result_arbiter_if #(.N_REQ(N), .RESULT_WIDTH(W)) bus();

  result_arbiter #(.N_REQ(N), .RESULT_WIDTH(W), .QUEUE_DEPTH(D)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic         wr;
    logic [W-1:0] data;
    logic [N-1:0] pend;
    logic [N-1:0] ovs;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  logic [W-1:0] mq [N][$];
  int           lg;
  logic [N-1:0] mflags;
  int           total = 0;
  int           bad   = 0;
  bit           mon_en = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    lg     = N - 1;
    mflags = '0;
  endfunction

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return {c, b, a};
  endfunction

  // One clock of stimulus; predicts this cycle's output, then the state after the edge
  task automatic cycle(input logic [N-1:0] wr, input logic [N*W-1:0] data, input logic full,
                       input logic fl = 1'b0, input logic clr = 1'b0);
    exp_t e;
    int g;
    logic [N-1:0] drops;
    @(posedge clock); #1;
    bus.req_wr_en      = wr;
    bus.req_data       = data;
    bus.fifo_full      = full;
    bus.flush          = fl;
    bus.clear_overflow = clr;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (lg + k) % N;
      if (g < 0 && mq[c].size() > 0) g = c;
    end
    e.wr   = (g >= 0) && !full;
    e.data = e.wr ? mq[g][0] : '0;
    for (int i = 0; i < N; i++) e.pend[i] = (mq[i].size() > 0);
    e.ovs = mflags;
    sb.push_back(e);
    mon_en = 1'b1;
    if (fl) model_reset();
    else begin
      if (e.wr) begin
        void'(mq[g].pop_front());
        lg = g;
      end
      drops = '0;
      for (int i = 0; i < N; i++)
        if (wr[i]) begin
          if (mq[i].size() < D) mq[i].push_back(data[i*W +: W]);
          else drops[i] = 1'b1;
        end
      mflags = (clr ? '0 : mflags) | drops;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
  endtask

  task automatic zero_inputs();
    bus.req_wr_en      = '0;
    bus.req_data       = '0;
    bus.fifo_full      = 1'b0;
    bus.flush          = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr"},   W'(bus.result_wr_en), '0);
    chk({tag, "_data"}, bus.result_data, '0);
    chk({tag, "_pend"}, W'(bus.pending), '0);
    chk({tag, "_idle"}, W'(bus.idle), W'(1));
    chk({tag, "_ovf"},  W'(bus.overflow), '0);
    chk({tag, "_ovs"},  W'(bus.overflow_src), '0);
  endtask

  // Monitor: every active cycle the DUT output is checked against the oldest prediction
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && resetn) begin
        if (sb.size() == 0) chk("sb_underflow", W'(1), W'(0));
        else begin
          me = sb.pop_front();
          chk("wr_en", W'(bus.result_wr_en), W'(me.wr));
          if (me.wr) chk("data", bus.result_data, me.data);
          chk("pending",  W'(bus.pending), W'(me.pend));
          chk("idle",     W'(bus.idle), W'(me.pend == '0));
          chk("ovf_src",  W'(bus.overflow_src), W'(me.ovs));
          chk("overflow", W'(bus.overflow), W'(|me.ovs));
        end
      end
    end
  end

  initial begin
    zero_inputs();
    model_reset();
    #12;
    chk_reset_outputs("rst");
    resetn = 1'b1;

    // Single word on the SPI slot
    cycle(3'b1 << REQ_SPI, pk(0, 32'hDEADBEEF, 0), 1'b0);
    idle_cycles(3);

    // Round-robin order, twice
    cycle(3'b111, pk(32'hA0, 32'hB0, 32'hC0), 1'b0);
    idle_cycles(4);
    cycle(3'b111, pk(32'hD0, 32'hE0, 32'hF0), 1'b0);
    idle_cycles(4);

    // Backpressure: fifth word into a full queue is dropped
    for (int i = 1; i <= 5; i++) cycle(3'b001, pk(W'(i), 0, 0), 1'b1);
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b1);
    idle_cycles(6);

    // Full queue 2 pushed while being popped: accepted
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(3'b100, pk(0, 0, W'(32'h70 + i)), 1'b1);
    cycle(3'b100, pk(0, 0, 32'h77), 1'b0);
    idle_cycles(6);

    // Drop coinciding with clear, then a lone clear
    for (int i = 1; i <= 4; i++) cycle(3'b010, pk(0, W'(32'h50 + i), 0), 1'b1);
    cycle(3'b010, pk(0, 32'h5F, 0), 1'b1, 1'b0, 1'b1);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1, 1'b0, 1'b1);
    idle_cycles(6);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 6; i++) cycle(3'b111, {$urandom, $urandom, $urandom}, 1'b0);
    @(posedge clock); #2;
    mon_en = 1'b0;
    resetn = 1'b0;
    zero_inputs();
    #1;
    chk_reset_outputs("async_rst");
    sb.delete();
    model_reset();
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    cycle(3'b111, pk(32'h11, 32'h22, 32'h33), 1'b0);
    idle_cycles(4);

    // Synchronous flush in the middle of a stream
    for (int i = 0; i < 6; i++) cycle(3'b111, {$urandom, $urandom, $urandom}, 1'b0);
    cycle(3'b111, {$urandom, $urandom, $urandom}, 1'b0, 1'b1);
    cycle(3'b111, pk(32'h44, 32'h55, 32'h66), 1'b0);
    idle_cycles(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(N'($urandom) & N'($urandom), {$urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 19) == 0);
    end
    idle_cycles(10);

    @(negedge clock); #1;
    chk("sb_drained", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_arbiter.md
# result_arbiter

Shares the single result-FIFO write port between the result producers of the pulse controller: DDS readback, SPI readback and loop-back data. Each requester gets a small private queue, so one-cycle write pulses are never lost while another source is writing or the FIFO is full. A round-robin arbiter drains the queues into the result FIFO at up to one word per cycle. Dropped words are reported per source through sticky overflow flags.

## Interface
- `N_REQ`, 3, number of requesters, 2..8; index 0 = DDS, 1 = SPI, 2 = loop-back.
- `RESULT_WIDTH`, 32, result word width.
- `QUEUE_DEPTH`, 4, entries per requester queue; power of 2, ≥2.

- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear; same effect as reset (driven from `init`).
- `req_wr_en`  in  N_REQ  one-cycle write pulse per requester.
- `req_data`  in  N_REQ*RESULT_WIDTH  requester i at `[i*RESULT_WIDTH +: RESULT_WIDTH]`; valid only with its `req_wr_en` bit.
- `fifo_full`  in  1  result FIFO full.
- `result_data`  out  RESULT_WIDTH  word being written; valid only while `result_wr_en` is high.
- `result_wr_en`  out  1  write strobe to the result FIFO.
- `pending`  out  N_REQ  queue i non-empty.
- `idle`  out  1  all queues empty.
- `overflow`  out  1  sticky; any word dropped.
- `overflow_src`  out  N_REQ  sticky; per-requester drop flag.
- `clear_overflow`  in  1  one-cycle clear of `overflow` and `overflow_src`.

## Operation
- **Queues.** Each requester has a FIFO of `QUEUE_DEPTH` words.
  - `req_wr_en[i]` pushes at the clock edge unless queue i is full and not popped in the same cycle.
  - Push and pop on a full queue in the same cycle: the push is accepted.
  - A rejected push drops the word and sets `overflow` and `overflow_src[i]`.
- **Arbitration.** Combinational round-robin over non-empty queues.
  - The search starts at `last_grant+1` (mod N_REQ).
  - `last_grant` resets to N_REQ-1, so requester 0 wins first.
  - `last_grant` updates only on an actual write.
- **Write port.**
  - `result_wr_en = |pending & ~fifo_full`.
  - `result_data` = head of the granted queue.
  - The granted queue pops at the same edge.
  - While `fifo_full` is high: no write, no pop, `last_grant` unchanged, queues keep filling.
- **Overflow flags.**
  - `clear_overflow` clears the sticky flags.
  - A drop in the same cycle as `clear_overflow` wins: its flag ends set.
- **Reset and flush.** Reset (async) or `flush` (sync) empties all queues, discards their data, clears flags, and resets `last_grant`.
  - Reset values: `result_wr_en` 0, `result_data` 0, `pending` 0, `idle` 1, `overflow` 0, `overflow_src` 0.
- **Data widths.** No width conversion; words pass unmodified.

## Timing
- No bypass path. A push in cycle k is at the earliest presented with `result_wr_en` in cycle k+1.
- Throughput: one word per cycle aggregate.
- Worst-case wait for a non-empty queue while the FIFO accepts: N_REQ-1 cycles.
- The combinational path from `fifo_full` to `result_wr_en` is intentional. The FIFO full flag must be registered in the FIFO.
- `pending`, `idle`, `overflow` and `overflow_src` reflect state after the last edge.
- Simultaneous pushes from all requesters every cycle exceed throughput; drops then follow the rules above.

## Configuration
- `RESULT_ARBITER_DBG_EN` defined: adds two outputs.
  - `dbg_grant_count` (N_REQ*32): per-requester count of written words.
  - `dbg_drop_count` (32): total dropped words.
  - Both wrap at 2^32, are cleared by reset/`flush`, and are not cleared by `clear_overflow`.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `result_arbiter_pkg`:
  - requester index constants `REQ_DDS=0`, `REQ_SPI=1`, `REQ_LOOPBACK=2`;
  - default `RESULT_WIDTH`/`QUEUE_DEPTH`;
  - `clog2`-based index width helper.
- Sub-module `result_arb_queue`: parameterized synchronous FIFO (width, depth) with push, pop, flush, full and empty.
  - Head is readable combinationally.
  - Instantiated N_REQ times via generate.
- Round-robin pick and sticky flags live in the top module.

## Test plan
- **Single word.** Reset, then `req_wr_en=3'b010`, data 0xDEADBEEF in cycle 0 → cycle 1: `result_wr_en=1`, data 0xDEADBEEF; `pending[1]` high in cycle 1, low and `idle=1` in cycle 2.
- **Round-robin order.** All three push 0xA0/0xB0/0xC0 in cycle 0 → writes in cycles 1, 2, 3 in order A0, B0, C0. A second simultaneous push D0/E0/F0 in cycle 5 → order D0, E0, F0 (rotation resumes after index 2).
- **Backpressure and drop.** `fifo_full=1` for 10 cycles; requester 0 pushes 5 words 1..5 → word 5 dropped, `overflow=1`, `overflow_src=3'b001`, no writes. Release → words 1..4 in consecutive cycles.
- **Full-queue push with pop.** Queue 2 full, `fifo_full=0`, only queue 2 pending, push 0x77 → no drop, `overflow=0`; 0x77 emitted after the 4 queued words.
- **Clear collision.** `clear_overflow` in the same cycle as a drop on requester 1 → `overflow=1`, `overflow_src=3'b010`. Lone `clear_overflow` → both 0.
- **Reset and flush mid-stream.**
  - `resetn` low during a stream of writes → `result_wr_en=0`, `pending=0` immediately (asynchronous). After release, the next pushes are granted from requester 0.
  - `flush` during the same stream → same effect at the next edge.
